// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM state encoding for the instruction-fetch stage.
// No logic; latency and backpressure are defined by the users of these types.
package fetch_stage_pkg;
    localparam int          WIDTH     = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  HALT_OPC  = 5'b00000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        HALTED   = 2'd2
    } state_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// PC register: WIDTH-bit, synchronous reset to RESET_PC, loads d when load=1.
// One-cycle latency, no backpressure; holds its value whenever load=0.
module pc_reg #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads imem, hands instruction and PC+2 to IF/ID.
// Delivery is combinational on imem_done; stall_fetch holds the PC, redirects win.
module fetch_stage #(
    parameter int               WIDTH     = fetch_stage_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR,
    parameter logic [4:0]       HALT_OPC  = fetch_stage_pkg::HALT_OPC
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_rd,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             imem_done,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             stall_fetch,
    output logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] incremented_pc,
    output logic             flush_fetch,
    output logic             halted
);
    import fetch_stage_pkg::state_t;
    import fetch_stage_pkg::RUN;
    import fetch_stage_pkg::WAIT_MEM;
    import fetch_stage_pkg::HALTED;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt, pc_plus2;
    logic             pc_ld;
    logic             pend_redirect, pend_redirect_nxt;
    logic [WIDTH-1:0] pend_pc, pend_pc_nxt;
    logic             deliver;
    logic             is_halt;

    pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_ld),
        .d    (pc_nxt),
        .q    (pc)
    );

    assign pc_plus2       = pc + WIDTH'(2);
    assign imem_addr      = pc;
    assign incremented_pc = pc_plus2;
    assign is_halt        = (imem_data[WIDTH-1 -: 5] == HALT_OPC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pend_redirect <= 1'b0;
            pend_pc       <= '0;
        end else begin
            state         <= state_nxt;
            pend_redirect <= pend_redirect_nxt;
            pend_pc       <= pend_pc_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        pc_ld             = 1'b0;
        pc_nxt            = pc;
        pend_redirect_nxt = pend_redirect;
        pend_pc_nxt       = pend_pc;
        imem_rd           = 1'b0;
        halted            = 1'b0;
        deliver           = 1'b0;

        case (state)
            RUN: begin
                imem_rd = 1'b1;
                if (redirect_valid) begin
                    if (imem_done) begin
                        pc_ld  = 1'b1;
                        pc_nxt = redirect_pc;
                    end else begin
                        pend_redirect_nxt = 1'b1;
                        pend_pc_nxt       = redirect_pc;
                        state_nxt         = WAIT_MEM;
                    end
                end else if (imem_done) begin
                    deliver = 1'b1;
                    if (!stall_fetch) begin
                        if (is_halt) begin
                            state_nxt = HALTED;
                        end else begin
                            pc_ld  = 1'b1;
                            pc_nxt = pc_plus2;
                        end
                    end
                end else begin
                    state_nxt = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (imem_done) begin
                    state_nxt         = RUN;
                    pend_redirect_nxt = 1'b0;
                    if (redirect_valid) begin
                        pc_ld  = 1'b1;
                        pc_nxt = redirect_pc;
                    end else if (pend_redirect) begin
                        pc_ld  = 1'b1;
                        pc_nxt = pend_pc;
                    end else begin
                        // A stalled delivery is dropped here and re-read from RUN.
                        deliver = 1'b1;
                        if (!stall_fetch) begin
                            if (is_halt) begin
                                state_nxt = HALTED;
                            end else begin
                                pc_ld  = 1'b1;
                                pc_nxt = pc_plus2;
                            end
                        end
                    end
                end else if (redirect_valid) begin
                    pend_redirect_nxt = 1'b1;
                    pend_pc_nxt       = redirect_pc;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (redirect_valid) begin
                    pc_ld     = 1'b1;
                    pc_nxt    = redirect_pc;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (rst) begin
            imem_rd = 1'b0;
            halted  = 1'b0;
            deliver = 1'b0;
        end
    end

    assign instruction = deliver ? imem_data : NOP_INSTR;
    assign flush_fetch = !deliver;
endmodule
